// File: rtl/seg7_pkg.sv
// seg7_pkg: nibble width and one-hot helper shared by the seg7 feeder and decoder
package seg7_pkg;
  localparam int NIBBLE_W = 4;
  function automatic logic [31:0] onehot(input logic [31:0] idx);
    return 32'd1 << idx;
  endfunction
endpackage

// File: rtl/seg7_sync_edge.sv
// seg7_sync_edge: multi-flop synchroniser for an async pin with rising-edge detect
module seg7_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic pin,
  output logic level,
  output logic rise
);
  logic [SYNC_STAGES-1:0] sync;
  logic prev;
  // shift the pin through the synchroniser and remember the last synchronised level
  always_ff @(posedge clk)
    if (reset) begin
      sync <= '0;
      prev <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], pin};
      prev <= sync[SYNC_STAGES-1];
    end
  assign level = sync[SYNC_STAGES-1];
  assign rise = level & ~prev;
endmodule

// File: rtl/seg7_serial_feeder.sv
// seg7_serial_feeder: serial-in, double-buffered, scanned nibble feeder; SEG7_FEED_BLANK_EN enables leading-zero blanking
module seg7_serial_feeder
  import seg7_pkg::*;
#(
  parameter int DIGITS      = 2,
  parameter int DIV         = 1024,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ser_data,
  input  logic                ser_shift,
  input  logic                ser_latch,
  input  logic                scan_hold,
  output logic [NIBBLE_W-1:0] nibble,
  output logic [DIGITS-1:0]   digit_sel,
  output logic                frame_tick,
  output logic                blank
);
  localparam int W  = NIBBLE_W * DIGITS;
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  localparam int PW = DIV > 1 ? $clog2(DIV) : 1;
  logic          data_level, data_rise, shift_level, shift_rise, latch_level, latch_rise;
  logic [W-1:0]  sr, disp;
  logic [PW-1:0] pre;
  logic [IW-1:0] idx;
  logic          wrap;
  logic          unused;
  seg7_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_data (
    .clk(clk), .reset(reset), .pin(ser_data), .level(data_level), .rise(data_rise)
  );
  seg7_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_shift (
    .clk(clk), .reset(reset), .pin(ser_shift), .level(shift_level), .rise(shift_rise)
  );
  seg7_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_latch (
    .clk(clk), .reset(reset), .pin(ser_latch), .level(latch_level), .rise(latch_rise)
  );
  assign unused = ^{data_rise, shift_level, latch_level};
  assign wrap = ~scan_hold & (pre == PW'(DIV - 1));
  // shift register and display buffer; a simultaneous latch captures the pre-shift word
  always_ff @(posedge clk)
    if (reset) begin
      sr   <= '0;
      disp <= '0;
    end else begin
      if (shift_rise) sr <= {sr[W-2:0], data_level};
      if (latch_rise) disp <= sr;
    end
  // scan prescaler, digit index and frame pulse, all frozen while scan_hold is high
  always_ff @(posedge clk)
    if (reset) begin
      pre        <= '0;
      idx        <= '0;
      frame_tick <= 1'b0;
    end else begin
      if (!scan_hold) pre <= wrap ? '0 : pre + PW'(1);
      if (wrap) idx <= (idx == IW'(DIGITS - 1)) ? '0 : idx + IW'(1);
      frame_tick <= wrap & (idx == IW'(DIGITS - 1));
    end
  // nibble and digit enable registered together so they never disagree
  always_ff @(posedge clk)
    if (reset) begin
      nibble    <= '0;
      digit_sel <= DIGITS'(1);
    end else begin
      nibble    <= disp[NIBBLE_W*idx +: NIBBLE_W];
      digit_sel <= DIGITS'(onehot(32'(idx)));
    end
`ifdef SEG7_FEED_BLANK_EN
  logic [DIGITS-1:0] zero_from;
  for (genvar k = 0; k < DIGITS; k++) begin : g_zero
    assign zero_from[k] = ~|disp[W-1:NIBBLE_W*k];
  end
  // blank a non-zero digit index when it and every higher nibble are zero
  always_ff @(posedge clk)
    if (reset) blank <= 1'b0;
    else blank <= (idx != '0) && zero_from[idx];
`else
  assign blank = 1'b0;
`endif
endmodule

// File: tb/tb_seg7_serial_feeder.sv
// tb_seg7_serial_feeder: scoreboard bench for seg7_serial_feeder against a word-level reference model
module tb_seg7_serial_feeder;
  localparam int DIGITS = 2;
  localparam int DIV    = 4;
  localparam int SS     = 2;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic ser_data = 1'b0;
  logic ser_shift = 1'b0;
  logic ser_latch = 1'b0;
  logic scan_hold = 1'b0;
  logic [3:0] nibble;
  logic [1:0] digit_sel;
  logic frame_tick;
  logic blank;
  typedef struct packed {
    logic [3:0] nib;
    logic [1:0] sel;
    logic       ft;
    logic       bl;
  } exp_t;
  exp_t q[$];
  int vectors = 0;
  int miscompares = 0;
  seg7_serial_feeder #(.DIGITS(DIGITS), .DIV(DIV), .SYNC_STAGES(SS)) dut (
    .clk(clk), .reset(reset), .ser_data(ser_data), .ser_shift(ser_shift),
    .ser_latch(ser_latch), .scan_hold(scan_hold), .nibble(nibble),
    .digit_sel(digit_sel), .frame_tick(frame_tick), .blank(blank)
  );
  always #5 clk = ~clk;
  // reference model: pins reach the core SS samples late; scan position derived from a count of unheld cycles
  logic [SS:0] hd = '0, hs = '0, hl = '0;
  logic [7:0] sr_m = '0, disp_m = '0;
  int cnt = 0;
  always @(posedge clk) begin
    exp_t e;
    int idx;
    logic sh, la;
    if (reset) begin
      hd = '0;
      hs = '0;
      hl = '0;
      sr_m = '0;
      disp_m = '0;
      cnt = 0;
      e = '{nib: 4'd0, sel: 2'b01, ft: 1'b0, bl: 1'b0};
    end else begin
      idx = (cnt / DIV) % DIGITS;
      e.nib = disp_m[4*idx +: 4];
      e.sel = 2'b01 << idx;
      e.ft = !scan_hold && ((cnt + 1) % (DIV * DIGITS) == 0);
`ifdef SEG7_FEED_BLANK_EN
      e.bl = (idx > 0) && ((disp_m >> (4 * idx)) == 8'h00);
`else
      e.bl = 1'b0;
`endif
      sh = hs[SS-1] & ~hs[SS];
      la = hl[SS-1] & ~hl[SS];
      if (!scan_hold) cnt++;
      if (la) disp_m = sr_m;
      if (sh) sr_m = {sr_m[6:0], hd[SS-1]};
      hd = {hd[SS-1:0], ser_data};
      hs = {hs[SS-1:0], ser_shift};
      hl = {hl[SS-1:0], ser_latch};
    end
    q.push_back(e);
  end
  // monitor: compare each registered output set with the model's expectation
  initial forever begin
    exp_t e;
    @(negedge clk);
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      vectors++;
      if ({nibble, digit_sel, frame_tick, blank} !== e) begin
        miscompares++;
        $display("FAIL outputs @%0t: got nibble=%h sel=%b ft=%b blank=%b, want nibble=%h sel=%b ft=%b blank=%b",
                 $time, nibble, digit_sel, frame_tick, blank, e.nib, e.sel, e.ft, e.bl);
      end
    end
  end
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic shift_bit(input logic b, input int hi, input int lo);
    ser_data = b;
    ser_shift = 1'b1;
    tick(hi);
    ser_shift = 1'b0;
    tick(lo);
  endtask
  task automatic send(input logic [7:0] w, input int nbits);
    for (int i = 7; i > 7 - nbits; i--) shift_bit(w[i], 4, 4);
  endtask
  task automatic latch();
    ser_latch = 1'b1;
    tick(4);
    ser_latch = 1'b0;
    tick(4);
  endtask
  initial begin
    logic [7:0] w;
    tick(3);
    reset = 1'b0;
    tick(10);
    send(8'hA5, 8);
    latch();
    tick(24);
    send(8'h3C, 8);
    ser_data = 1'b1;
    ser_shift = 1'b1;
    ser_latch = 1'b1;
    tick(4);
    ser_shift = 1'b0;
    ser_latch = 1'b0;
    tick(12);
    latch();
    tick(16);
    tick(5);
    scan_hold = 1'b1;
    tick(20);
    scan_hold = 1'b0;
    tick(12);
    send(8'hFF, 5);
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(4);
    latch();
    tick(10);
    send(8'h96, 8);
    latch();
    tick(12);
    send(8'h07, 8);
    latch();
    tick(12);
    send(8'h00, 8);
    latch();
    tick(10);
    repeat (30) begin
      w = 8'($urandom);
      for (int i = 7; i >= 0; i--) begin
        scan_hold = ($urandom_range(0, 7) == 0);
        shift_bit(w[i], $urandom_range(1, 5), $urandom_range(1, 5));
      end
      scan_hold = 1'b0;
      if ($urandom_range(0, 3) != 0) latch();
      tick($urandom_range(0, 9));
    end
    repeat (400) begin
      ser_data = 1'($urandom);
      ser_shift = 1'($urandom);
      ser_latch = ($urandom_range(0, 5) == 0);
      scan_hold = ($urandom_range(0, 5) == 0);
      reset = ($urandom_range(0, 63) == 0);
      tick(1);
    end
    reset = 1'b0;
    scan_hold = 1'b0;
    ser_shift = 1'b0;
    ser_latch = 1'b0;
    tick(5);
    #2;
    if (vectors < 12) begin
      miscompares++;
      $display("FAIL vector_count: got %0d, want at least 12", vectors);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
